// File: rtl/logic_op_sequencer.sv
// Single-transaction sequencer around the registered bitwise logic unit:
// accepts a request, drives the unit's operands, captures the flagged result.
module logic_op_sequencer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_req_valid,
   output logic             o_req_ready,
   input  logic [3:0]       i_req_op,
   input  logic [WIDTH-1:0] i_req_lhs,
   input  logic [WIDTH-1:0] i_req_rhs,
   output logic [3:0]       o_lu_operation,
   output logic [WIDTH-1:0] o_lu_lhs,
   output logic [WIDTH-1:0] o_lu_rhs,
   input  logic [WIDTH-1:0] i_lu_result,
   output logic             o_res_valid,
   input  logic             i_res_ready,
   output logic [WIDTH-1:0] o_res_data,
   output logic             o_res_zero,
   output logic             o_res_neg,
   output logic             o_res_parity,
   output logic             o_busy
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_CAPT  = 2'd2;
   localparam logic [1:0] S_HOLD  = 2'd3;

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic             w_accept;
   logic             w_capture;
   logic             w_release;

   logic [3:0]       r_lu_operation;
   logic [WIDTH-1:0] r_lu_lhs;
   logic [WIDTH-1:0] r_lu_rhs;
   logic [WIDTH-1:0] r_res_data;
   logic             r_res_valid;
   logic             r_res_zero;
   logic             r_res_neg;
   logic             r_res_parity;
   logic             r_busy;
   logic             r_req_ready;

   // Next-state and transaction strobes
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_capture   = 1'b0;
      w_release   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_req_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: w_state_nxt = S_CAPT;
         S_CAPT: begin
            w_capture   = 1'b1;
            w_state_nxt = S_HOLD;
         end
         S_HOLD: begin
            if (i_res_ready) begin
               w_release   = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // req_ready/busy are registered copies of the next-state decode
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_req_ready <= 1'b1;
         r_busy      <= 1'b0;
      end else begin
         r_req_ready <= (w_state_nxt == S_IDLE);
         r_busy      <= (w_state_nxt != S_IDLE);
      end
   end

   // Operand registers toward the logic unit; held between transactions
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lu_operation <= 4'd0;
         r_lu_lhs       <= '0;
         r_lu_rhs       <= '0;
      end else if (w_accept) begin
         r_lu_operation <= i_req_op;
         r_lu_lhs       <= i_req_lhs;
         r_lu_rhs       <= i_req_rhs;
      end
   end

   // Result and flags captured together from the same lu_result sample
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_res_data   <= '0;
         r_res_zero   <= 1'b0;
         r_res_neg    <= 1'b0;
         r_res_parity <= 1'b0;
         r_res_valid  <= 1'b0;
      end else begin
         if (w_capture) begin
            r_res_data   <= i_lu_result;
            r_res_zero   <= (i_lu_result == '0);
            r_res_neg    <= i_lu_result[WIDTH-1];
            r_res_parity <= ^i_lu_result;
            r_res_valid  <= 1'b1;
         end else if (w_release) begin
            r_res_valid  <= 1'b0;
         end
      end
   end

   assign o_req_ready    = r_req_ready;
   assign o_busy         = r_busy;
   assign o_lu_operation = r_lu_operation;
   assign o_lu_lhs       = r_lu_lhs;
   assign o_lu_rhs       = r_lu_rhs;
   assign o_res_valid    = r_res_valid;
   assign o_res_data     = r_res_data;
   assign o_res_zero     = r_res_zero;
   assign o_res_neg      = r_res_neg;
   assign o_res_parity   = r_res_parity;

endmodule

// File: tb/tb_logic_op_sequencer.sv
// Directed and random checks of logic_op_sequencer with a registered
// truth-table logic unit model closing the loop on lu_* / lu_result.
module tb_logic_op_sequencer;

   localparam int unsigned WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             i_req_valid = 1'b0;
   logic             o_req_ready;
   logic [3:0]       i_req_op = 4'd0;
   logic [WIDTH-1:0] i_req_lhs = '0;
   logic [WIDTH-1:0] i_req_rhs = '0;
   logic [3:0]       o_lu_operation;
   logic [WIDTH-1:0] o_lu_lhs;
   logic [WIDTH-1:0] o_lu_rhs;
   logic [WIDTH-1:0] lu_result = '0;
   logic             o_res_valid;
   logic             i_res_ready = 1'b0;
   logic [WIDTH-1:0] o_res_data;
   logic             o_res_zero;
   logic             o_res_neg;
   logic             o_res_parity;
   logic             o_busy;

   int n_cmp = 0;
   int n_err = 0;

   logic_op_sequencer #(.WIDTH(WIDTH)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_req_valid   (i_req_valid),
      .o_req_ready   (o_req_ready),
      .i_req_op      (i_req_op),
      .i_req_lhs     (i_req_lhs),
      .i_req_rhs     (i_req_rhs),
      .o_lu_operation(o_lu_operation),
      .o_lu_lhs      (o_lu_lhs),
      .o_lu_rhs      (o_lu_rhs),
      .i_lu_result   (lu_result),
      .o_res_valid   (o_res_valid),
      .i_res_ready   (i_res_ready),
      .o_res_data    (o_res_data),
      .o_res_zero    (o_res_zero),
      .o_res_neg     (o_res_neg),
      .o_res_parity  (o_res_parity),
      .o_busy        (o_busy)
   );

   always #5 clk = ~clk;

   // Logic unit: result bit i = op[{rhs[i], lhs[i]}], registered on clk
   function automatic logic [WIDTH-1:0] lu_eval(input logic [3:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] r;
      for (int i = 0; i < int'(WIDTH); i++) r[i] = op[{b[i], a[i]}];
      return r;
   endfunction

   always @(posedge clk) lu_result <= lu_eval(o_lu_operation, o_lu_lhs, o_lu_rhs);

   // Scoreboard reference written as named boolean operations
   function automatic logic [WIDTH-1:0] ref_op(input logic [3:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
      case (op)
         4'h0: return '0;
         4'h1: return ~(a | b);
         4'h2: return a & ~b;
         4'h3: return ~b;
         4'h4: return ~a & b;
         4'h5: return ~a;
         4'h6: return a ^ b;
         4'h7: return ~(a & b);
         4'h8: return a & b;
         4'h9: return ~(a ^ b);
         4'hA: return a;
         4'hB: return a | ~b;
         4'hC: return b;
         4'hD: return ~a | b;
         4'hE: return a | b;
         default: return '1;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one request for exactly one accept edge (caller ensures IDLE)
   task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      i_req_valid = 1'b1;
      i_req_op    = op;
      i_req_lhs   = a;
      i_req_rhs   = b;
      tick();
      i_req_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      n_cmp++;
      if ({o_req_ready, o_busy, o_res_valid, o_res_zero, o_res_neg, o_res_parity} !== 6'b100000) begin
         n_err++;
         $display("FAIL reset_ctrl got %b want 100000",
                  {o_req_ready, o_busy, o_res_valid, o_res_zero, o_res_neg, o_res_parity});
      end
      n_cmp++;
      if ({o_lu_operation, o_lu_lhs, o_lu_rhs, o_res_data} !== 28'h0) begin
         n_err++;
         $display("FAIL reset_data got %h want 0", {o_lu_operation, o_lu_lhs, o_lu_rhs, o_res_data});
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_and();
      i_res_ready = 1'b1;
      send(4'b1000, 8'hF0, 8'h3C);
      n_cmp++;
      if ({o_lu_operation, o_lu_lhs, o_lu_rhs} !== {4'b1000, 8'hF0, 8'h3C}) begin
         n_err++;
         $display("FAIL and_lu_regs got %h want 8f03c", {o_lu_operation, o_lu_lhs, o_lu_rhs});
      end
      n_cmp++;
      if ({o_busy, o_req_ready, o_res_valid} !== 3'b100) begin
         n_err++;
         $display("FAIL and_issue_ctrl got %b want 100", {o_busy, o_req_ready, o_res_valid});
      end
      tick();
      n_cmp++;
      if ({o_busy, o_res_valid} !== 2'b10) begin
         n_err++;
         $display("FAIL and_capt_ctrl got %b want 10", {o_busy, o_res_valid});
      end
      tick();
      n_cmp++;
      if ({o_busy, o_res_valid, o_res_data, o_res_zero, o_res_neg, o_res_parity} !== {2'b11, 8'h30, 3'b000}) begin
         n_err++;
         $display("FAIL and_result got %h want %h",
                  {o_busy, o_res_valid, o_res_data, o_res_zero, o_res_neg, o_res_parity}, {2'b11, 8'h30, 3'b000});
      end
      tick();
      n_cmp++;
      if ({o_busy, o_res_valid, o_req_ready, o_res_data} !== {3'b001, 8'h30}) begin
         n_err++;
         $display("FAIL and_release got %h want %h", {o_busy, o_res_valid, o_req_ready, o_res_data}, {3'b001, 8'h30});
      end
   endtask

   task automatic test_xor_zero();
      i_res_ready = 1'b1;
      send(4'b0110, 8'hAA, 8'hAA);
      tick();
      tick();
      n_cmp++;
      if ({o_res_valid, o_res_data, o_res_zero, o_res_neg, o_res_parity} !== {1'b1, 8'h00, 3'b100}) begin
         n_err++;
         $display("FAIL xor_zero got %h want %h",
                  {o_res_valid, o_res_data, o_res_zero, o_res_neg, o_res_parity}, {1'b1, 8'h00, 3'b100});
      end
      tick();
   endtask

   task automatic test_nor_flags();
      i_res_ready = 1'b1;
      send(4'b0001, 8'h0F, 8'h10);
      tick();
      tick();
      n_cmp++;
      if ({o_res_valid, o_res_data, o_res_zero, o_res_neg, o_res_parity} !== {1'b1, 8'hE0, 3'b011}) begin
         n_err++;
         $display("FAIL nor_flags got %h want %h",
                  {o_res_valid, o_res_data, o_res_zero, o_res_neg, o_res_parity}, {1'b1, 8'hE0, 3'b011});
      end
      tick();
      send(4'b1111, 8'h12, 8'h34);
      tick();
      tick();
      n_cmp++;
      if ({o_res_valid, o_res_data, o_res_zero, o_res_neg, o_res_parity} !== {1'b1, 8'hFF, 3'b010}) begin
         n_err++;
         $display("FAIL ones_flags got %h want %h",
                  {o_res_valid, o_res_data, o_res_zero, o_res_neg, o_res_parity}, {1'b1, 8'hFF, 3'b010});
      end
      tick();
   endtask

   task automatic test_backpressure();
      i_res_ready = 1'b0;
      send(4'b1110, 8'h81, 8'h02);
      // second request waits on req_valid for the whole transaction
      i_req_valid = 1'b1;
      i_req_op    = 4'b0111;
      i_req_lhs   = 8'hFF;
      i_req_rhs   = 8'h0F;
      tick();
      tick();
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if ({o_res_valid, o_req_ready, o_res_data, o_res_zero, o_res_neg, o_res_parity, o_lu_operation}
             !== {2'b10, 8'h83, 3'b011, 4'b1110}) begin
            n_err++;
            $display("FAIL bp_hold[%0d] got %h want %h", i,
                     {o_res_valid, o_req_ready, o_res_data, o_res_zero, o_res_neg, o_res_parity, o_lu_operation},
                     {2'b10, 8'h83, 3'b011, 4'b1110});
         end
         tick();
      end
      i_res_ready = 1'b1;
      tick();
      n_cmp++;
      if ({o_res_valid, o_req_ready, o_lu_operation, o_res_data} !== {2'b01, 4'b1110, 8'h83}) begin
         n_err++;
         $display("FAIL bp_release got %h want %h", {o_res_valid, o_req_ready, o_lu_operation, o_res_data},
                  {2'b01, 4'b1110, 8'h83});
      end
      tick();
      i_req_valid = 1'b0;
      n_cmp++;
      if ({o_busy, o_req_ready, o_lu_operation, o_lu_lhs, o_lu_rhs} !== {2'b10, 4'b0111, 8'hFF, 8'h0F}) begin
         n_err++;
         $display("FAIL bp_second_accept got %h want %h", {o_busy, o_req_ready, o_lu_operation, o_lu_lhs, o_lu_rhs},
                  {2'b10, 4'b0111, 8'hFF, 8'h0F});
      end
      tick();
      tick();
      n_cmp++;
      if ({o_res_valid, o_res_data, o_res_zero, o_res_neg, o_res_parity} !== {1'b1, 8'hF0, 3'b010}) begin
         n_err++;
         $display("FAIL bp_second_result got %h want %h",
                  {o_res_valid, o_res_data, o_res_zero, o_res_neg, o_res_parity}, {1'b1, 8'hF0, 3'b010});
      end
      tick();
   endtask

   task automatic test_reset_midop();
      i_res_ready = 1'b1;
      send(4'b1000, 8'hFF, 8'hFF);
      tick();
      // now in CAPT: assert reset between edges
      rst_n = 1'b0;
      #2;
      n_cmp++;
      if ({o_res_valid, o_busy, o_req_ready, o_lu_operation, o_lu_lhs, o_lu_rhs, o_res_data,
           o_res_zero, o_res_neg, o_res_parity} !== {3'b001, 28'h0, 3'b000}) begin
         n_err++;
         $display("FAIL midop_async_reset got %h want %h",
                  {o_res_valid, o_busy, o_req_ready, o_lu_operation, o_lu_lhs, o_lu_rhs, o_res_data,
                   o_res_zero, o_res_neg, o_res_parity}, {3'b001, 28'h0, 3'b000});
      end
      tick();
      tick();
      n_cmp++;
      if (o_res_valid !== 1'b0) begin
         n_err++;
         $display("FAIL midop_no_result got %b want 0", o_res_valid);
      end
      rst_n = 1'b1;
      send(4'b1100, 8'h33, 8'h5A);
      n_cmp++;
      if ({o_busy, o_lu_operation} !== {1'b1, 4'b1100}) begin
         n_err++;
         $display("FAIL midop_first_accept got %h want %h", {o_busy, o_lu_operation}, {1'b1, 4'b1100});
      end
      tick();
      tick();
      n_cmp++;
      if ({o_res_valid, o_res_data, o_res_zero, o_res_neg, o_res_parity} !== {1'b1, 8'h5A, 3'b000}) begin
         n_err++;
         $display("FAIL bpass_result got %h want %h",
                  {o_res_valid, o_res_data, o_res_zero, o_res_neg, o_res_parity}, {1'b1, 8'h5A, 3'b000});
      end
      tick();
   endtask

   task automatic test_back_to_back();
      localparam int N_OPS = 1000;
      logic [WIDTH-1:0] exp_q[$];
      logic [WIDTH-1:0] exp_d;
      logic [3:0]       op;
      logic [7:0]       a, b;
      logic             have_req, acc, rel;
      logic [WIDTH-1:0] got_d;
      logic [2:0]       got_f;
      int               sent, rcvd, cycles;
      have_req = 1'b0;
      sent = 0;
      rcvd = 0;
      cycles = 0;
      while (rcvd < N_OPS && cycles < 20000) begin
         if (!have_req && sent < N_OPS && $urandom_range(0, 3) != 0) begin
            op = 4'($urandom_range(0, 15));
            a  = 8'($urandom);
            b  = 8'($urandom);
            i_req_op  = op;
            i_req_lhs = a;
            i_req_rhs = b;
            have_req  = 1'b1;
         end
         i_req_valid = have_req;
         i_res_ready = 1'($urandom_range(0, 1));
         acc   = i_req_valid && o_req_ready;
         rel   = o_res_valid && i_res_ready;
         got_d = o_res_data;
         got_f = {o_res_zero, o_res_neg, o_res_parity};
         tick();
         cycles++;
         if (acc) begin
            exp_q.push_back(ref_op(op, a, b));
            have_req = 1'b0;
            sent++;
         end
         if (rel) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL stream_spurious got result %h want none", got_d);
            end else begin
               exp_d = exp_q.pop_front();
               if ({got_d, got_f} !== {exp_d, (exp_d == '0), exp_d[WIDTH-1], ^exp_d}) begin
                  n_err++;
                  $display("FAIL stream_result[%0d] got %h want %h", rcvd, {got_d, got_f},
                           {exp_d, (exp_d == '0), exp_d[WIDTH-1], ^exp_d});
               end
            end
            rcvd++;
         end
      end
      i_req_valid = 1'b0;
      n_cmp++;
      if (rcvd != N_OPS || sent != N_OPS || exp_q.size() != 0) begin
         n_err++;
         $display("FAIL stream_count got sent=%0d rcvd=%0d pending=%0d want %0d/%0d/0",
                  sent, rcvd, exp_q.size(), N_OPS, N_OPS);
      end
   endtask

   initial begin
      test_reset();
      test_and();
      test_xor_zero();
      test_nor_flags();
      test_backpressure();
      test_reset_midop();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/logic_op_sequencer.md
# logic_op_sequencer

Operand/result sequencer wrapped around the bitwise logic unit of the ALU. It accepts a logic-operation request over a valid/ready handshake and registers the 4-bit operation code and both operands onto the logic unit's inputs. It waits out the logic unit's one-cycle registered latency, then captures the result with zero/negative/parity flags. The result is presented over a second valid/ready handshake toward the register-file write-back path.

## Interface
- WIDTH, 8, operand/result width in bits (must be ≥ 2)

- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request (high only in IDLE)
- req_op  in  4  logic-unit operation code, same encoding as the logic unit
- req_lhs  in  WIDTH  left operand
- req_rhs  in  WIDTH  right operand
- lu_operation  out  4  registered operation code to logic unit
- lu_lhs  out  WIDTH  registered left operand to logic unit
- lu_rhs  out  WIDTH  registered right operand to logic unit
- lu_result  in  WIDTH  logic unit output, registered inside the logic unit on clk
- res_valid  out  1  result and flags valid
- res_ready  in  1  consumer accepts result
- res_data  out  WIDTH  captured result
- res_zero  out  1  res_data == 0
- res_neg  out  1  res_data[WIDTH-1]
- res_parity  out  1  XOR-reduction of res_data (1 = odd number of ones)
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ISSUE, CAPT, HOLD.
- IDLE: req_ready=1. When req_valid && req_ready at an edge, load lu_operation/lu_lhs/lu_rhs from req_* and go to ISSUE.
- ISSUE: lu_* stable. The logic unit samples them at this edge. Go to CAPT.
- CAPT: lu_result is valid. At the edge, load res_data from lu_result, compute the three flags from that same value, set res_valid=1, and go to HOLD.
- HOLD: res_valid=1. res_data and the flags are held stable. When res_ready=1 at the edge, clear res_valid and go to IDLE.
- lu_* keep their last values in every state except the IDLE accept edge. They are never cleared after a transaction.
- res_data and the flags keep their last values after the handshake. Only res_valid drops.
- Flags are registered alongside res_data, never computed combinationally from lu_result.
- Only one transaction is in flight. No back-to-back overlap, and a request is never accepted in HOLD, even if res_ready is high.
- req_op is passed through unmodified. All 16 codes are legal.

## Timing
- Reset (rst_n=0, async): state=IDLE, lu_operation=0, lu_lhs=0, lu_rhs=0, res_data=0, res_valid=0, res_zero=0, res_neg=0, res_parity=0, busy=0, req_ready=1.
- Accept at edge E0. Then: ISSUE in cycle after E0, logic unit samples at E1, capture at E2, res_valid high from E2.
- Latency from accept to res_valid: 2 cycles. With res_ready held high, occupancy is 3 cycles.
- Minimum request spacing: 4 edges (accept, issue, capture, release; next accept at the following edge).
- req_ready is a pure function of state (no combinational path from req_valid). res_valid is a registered output.
- Reset asserted mid-operation (any of ISSUE/CAPT/HOLD): immediate return to reset values. The in-flight result is discarded and never presented. The first accept is possible at the first edge after rst_n deasserts.
- req_valid dropping while in ISSUE/CAPT/HOLD has no effect. Operands were already captured.

## Test plan
- AND (op 4'b1000), lhs 0xF0, rhs 0x3C, res_ready=1 -> res_valid 2 cycles after accept, res_data 0x30, zero=0, neg=0, parity=0. busy high for 3 cycles.
- XOR (op 4'b0110), lhs 0xAA, rhs 0xAA -> res_data 0x00, zero=1, neg=0, parity=0.
- NOR (op 4'b0001), lhs 0x0F, rhs 0x10 -> res_data 0xE0, zero=0, neg=1, parity=1. Then op 4'b1111 -> 0xFF, neg=1, parity=0.
- Backpressure: res_ready low for 5 cycles after res_valid, second request held on req_valid -> res_data/flags stable, req_ready=0, second request accepted only at the edge after res_ready handshake completes.
- Reset mid-op: assert rst_n=0 during CAPT -> res_valid stays 0, all outputs at reset values asynchronously. After release, request B-pass (op 4'b1100) rhs 0x5A -> res_data 0x5A, parity=0.
- Random back-to-back stream (≥1000 ops, random res_ready): scoreboard each result against a software model of all 16 opcodes. No request is lost or duplicated.
